// File: rtl/fb_page_controller.sv
// fb_page_controller: double-buffer page-flip controller for a two-page 12-bit frame buffer.
// Define FB_AUTO_CLEAR_EN to fill the new back page with clear_color after every flip.
module fb_page_controller #(
    parameter int PAGE_WORDS = 76800,
    parameter int ADDR_W     = 18
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              vblank,
    input  logic [16:0]       disp_addr_in,
    output logic [ADDR_W-1:0] disp_addr_out,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [16:0]       wr_addr,
    input  logic [11:0]       wr_data,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [11:0]       mem_wdata,
    input  logic              swap_req,
    input  logic [11:0]       clear_color,
    output logic              swap_busy,
    output logic              swap_done,
    output logic              front_page
);
    localparam logic [ADDR_W-1:0] PAGE_BASE = ADDR_W'(PAGE_WORDS);
    localparam logic [16:0]       LAST_WORD = 17'(PAGE_WORDS - 1);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_VB,
        FLIP,
`ifdef FB_AUTO_CLEAR_EN
        CLEAR,
`endif
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic              front_q, front_d;
    logic              wr_ready_q, wr_ready_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_waddr_q, mem_waddr_d;
    logic [11:0]       mem_wdata_q, mem_wdata_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              vblank_q;
    logic              vb_rise;
    logic [ADDR_W-1:0] back_base;

`ifdef FB_AUTO_CLEAR_EN
    logic [11:0] clr_q, clr_d;
    logic [16:0] cnt_q, cnt_d;
`else
    logic unused_clear_color;
    assign unused_clear_color = ^clear_color;
`endif

    assign vb_rise       = vblank & ~vblank_q;
    assign back_base     = front_q ? '0 : PAGE_BASE;
    assign disp_addr_out = ADDR_W'(disp_addr_in) + (front_q ? PAGE_BASE : '0);
    assign front_page    = front_q;
    assign wr_ready      = wr_ready_q;
    assign mem_we        = mem_we_q;
    assign mem_waddr     = mem_waddr_q;
    assign mem_wdata     = mem_wdata_q;
    assign swap_busy     = busy_q;
    assign swap_done     = done_q;

    always_comb begin
        state_d     = state_q;
        front_d     = front_q;
        mem_we_d    = 1'b0;
        mem_waddr_d = mem_waddr_q;
        mem_wdata_d = mem_wdata_q;
`ifdef FB_AUTO_CLEAR_EN
        clr_d       = clr_q;
        cnt_d       = cnt_q;
`endif
        // out-of-page addresses complete the handshake but never reach memory
        if (wr_valid && wr_ready_q && wr_addr <= LAST_WORD) begin
            mem_we_d    = 1'b1;
            mem_waddr_d = back_base + ADDR_W'(wr_addr);
            mem_wdata_d = wr_data;
        end
        case (state_q)
            IDLE: begin
                if (swap_req) begin
                    state_d = WAIT_VB;
`ifdef FB_AUTO_CLEAR_EN
                    clr_d   = clear_color;
`endif
                end
            end
            WAIT_VB: begin
                if (vb_rise) begin
                    state_d = FLIP;
                    front_d = ~front_q;
                end
            end
            FLIP: begin
`ifdef FB_AUTO_CLEAR_EN
                state_d = CLEAR;
                cnt_d   = '0;
`else
                state_d = DONE;
`endif
            end
`ifdef FB_AUTO_CLEAR_EN
            CLEAR: begin
                mem_we_d    = 1'b1;
                mem_waddr_d = back_base + ADDR_W'(cnt_q);
                mem_wdata_d = clr_q;
                cnt_d       = cnt_q + 17'd1;
                if (cnt_q == LAST_WORD) state_d = DONE;
            end
`endif
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        wr_ready_d = (state_d == IDLE);
        busy_d     = (state_d != IDLE);
        done_d     = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            front_q     <= 1'b0;
            wr_ready_q  <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_waddr_q <= '0;
            mem_wdata_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            vblank_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            front_q     <= front_d;
            wr_ready_q  <= wr_ready_d;
            mem_we_q    <= mem_we_d;
            mem_waddr_q <= mem_waddr_d;
            mem_wdata_q <= mem_wdata_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            vblank_q    <= vblank;
        end
    end

`ifdef FB_AUTO_CLEAR_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clr_q <= '0;
            cnt_q <= '0;
        end else begin
            clr_q <= clr_d;
            cnt_q <= cnt_d;
        end
    end
`endif
endmodule

// File: doc/fb_page_controller.md
Name: fb_page_controller

Overview:
- Double-buffer (page-flip) controller for the 320x240 12-bit frame buffer memory, which holds two pages of PAGE_WORDS pixels each.
- Offsets the display scaler's 17-bit read address onto the front page.
- Accepts renderer pixel writes through a valid/ready handshake and steers them onto the back page.
- Sequences a tear-free page swap aligned to the start of vertical blanking, optionally followed by a hardware clear of the new back page.

Parameters:
PAGE_WORDS, 76800, pixels per page (320x240); page 1 base address = PAGE_WORDS
ADDR_W, 18, physical memory address width (must hold 2*PAGE_WORDS-1)

Ports:
clk  input  1  system/pixel clock
reset_n  input  1  asynchronous, active-low reset
vblank  input  1  high during vertical blanking, synchronous to clk
disp_addr_in  input  17  pixel address from display scaler (0..PAGE_WORDS-1)
disp_addr_out  output  ADDR_W  physical read address to frame buffer memory
wr_valid  input  1  renderer write request
wr_ready  output  1  controller can accept a write this cycle
wr_addr  input  17  renderer pixel address within page
wr_data  input  12  renderer RGB444 pixel
mem_we  output  1  memory write enable
mem_waddr  output  ADDR_W  physical write address
mem_wdata  output  12  write data
swap_req  input  1  single-cycle pulse requesting a page flip
clear_color  input  12  fill colour for auto-clear (sampled at swap_req acceptance)
swap_busy  output  1  high while a swap (and clear) is in progress
swap_done  output  1  single-cycle pulse when swap sequence completes
front_page  output  1  page currently displayed

Behaviour:
- Reset values: front_page=0, wr_ready=0, mem_we=0, mem_waddr=0, mem_wdata=0, swap_busy=0, swap_done=0, state=IDLE, vblank_d=0.
- disp_addr_out is combinational: disp_addr_in + (front_page ? PAGE_WORDS : 0), zero-extended to ADDR_W. No added latency on the read path.
- Back page = ~front_page. back_base = back page ? PAGE_WORDS : 0.
- Write path:
  - Transfer occurs when wr_valid & wr_ready are both high at a clk edge.
  - Next cycle: mem_we=1, mem_waddr=back_base+wr_addr, mem_wdata=wr_data. Latency is 1 cycle.
  - wr_addr >= PAGE_WORDS: the write is handshaken but dropped (mem_we=0).
- wr_ready is registered, 1 only in IDLE. It rises on the first clk after reset release and drops the cycle after swap_req is accepted.
- vblank rising edge (vb_rise) = vblank & ~vblank_d, where vblank_d is registered.
- States:
  - IDLE: swap_busy=0. On swap_req: latch clear_color, go to WAIT_VB, swap_busy=1. A write handshaken in the same cycle as swap_req is still performed to the old back page.
  - WAIT_VB: wait for vb_rise. If swap_req arrives while vblank is already high, the controller still waits for the next rising edge (guarantees one full frame was rendered). Then go to FLIP.
  - FLIP: one cycle; toggle front_page. Next state is CLEAR when FB_AUTO_CLEAR_EN is compiled in, else DONE.
  - CLEAR: see Optional Feature.
  - DONE: one cycle; swap_done=1, swap_busy drops, return to IDLE, wr_ready=1 next cycle.
- swap_req while swap_busy=1 is ignored (no queueing, no error).
- front_page changes only in the cycle after a vblank rising edge, so the displayed page never changes mid-frame.
- Asserting reset_n low mid-sequence aborts immediately: all outputs return to their reset values, front_page=0, and any clear in progress is abandoned.

Optional Feature:
- Macro: FB_AUTO_CLEAR_EN.
- Defined: after FLIP, state CLEAR writes the latched clear_color to every back-page word.
  - Counter runs 0..PAGE_WORDS-1; each cycle mem_we=1, mem_waddr=back_base+cnt (back page after the flip).
  - Exactly PAGE_WORDS write cycles, then DONE.
  - wr_ready stays 0 throughout.
- Not defined: the CLEAR state and its counter are not generated; FLIP goes straight to DONE; clear_color is ignored.

Test Plan:
- Reset release, then write wr_addr=5, data=12'hF00 with front_page=0 -> wr_ready=1 one cycle after release; next cycle mem_we=1, mem_waddr=76805, mem_wdata=F00.
- wr_addr=76800 handshaken -> no mem_we pulse; wr_ready stays 1.
- swap_req in active video, vblank rises 1000 cycles later -> wr_ready=0 from the next cycle; front_page toggles 1 cycle after vb_rise; disp_addr_in=10 then gives disp_addr_out=76810; swap_done pulses (no clear build).
- swap_req while vblank already high -> no flip until the following vblank rising edge; a second swap_req while busy produces exactly one toggle.
- FB_AUTO_CLEAR_EN, clear_color=12'h0A5, front_page 0->1 -> exactly 76800 writes of 0A5 at addresses 0..76799, then swap_done; total swap_busy time = wait + 1 + 76800 + 1 cycles.
- reset_n low during CLEAR at count 300 -> mem_we=0 and front_page=0 immediately; after release, wr_ready=1 and the state is IDLE.
